// File: rtl/cfg_bank_loader.sv
// Sequences LOAD/CLEAR/SET commands into a WORDS x WIDTH bank of enabled, resettable config flops.
// Latency: a SWEEP of n words completes with done n cycles after the accept edge; a LOAD completes with done the cycle after its last data handshake.
// Backpressure: cmd_ready is high only in IDLE; wr_ready is high only in LOAD; a SWEEP never stalls.
// Ports: clk/R (async active-low reset); cmd_* command port; wr_* LOAD data port;
//        abort; busy/done/aborted status; rd_addr/rd_data combinational readback;
//        cfg_q flattened bank (word i at [i*WIDTH +: WIDTH]).
module cfg_bank_loader #(
    parameter int              WORDS   = 8,
    parameter int              WIDTH   = 8,
    parameter int              AW      = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [AW-1:0]          cmd_len,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic [WORDS*WIDTH-1:0] cfg_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic             aborted_q, aborted_d;
    logic [WIDTH-1:0] bank_q [WORDS];
    logic [WIDTH-1:0] bank_d [WORDS];
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        fill_d    = fill_q;
        aborted_d = 1'b0;
        wr_en     = 1'b0;
        wr_val    = fill_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ptr_d  = cmd_addr;
                    rem_d  = cmd_len;
                    fill_d = (cmd_op == OP_SET) ? '1 : '0;
                    if (cmd_op == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (cmd_op == OP_CLEAR || cmd_op == OP_SET) begin
                        state_d = S_SWEEP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD, S_SWEEP: begin
                // Abort wins over any write offered in the same cycle.
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (state_q == S_SWEEP || wr_valid) begin
                    wr_en  = 1'b1;
                    wr_val = (state_q == S_LOAD) ? wr_data : fill_q;
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // WORDS is a power of two, so the pointer wraps naturally.
                        ptr_d = ptr_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only the addressed word is enabled; every other word holds.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            bank_d[i] = (wr_en && ptr_q == AW'(i)) ? wr_val : bank_q[i];
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            fill_q    <= '0;
            aborted_q <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                bank_q[i] <= RST_VAL;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            fill_q    <= fill_d;
            aborted_q <= aborted_d;
            for (int i = 0; i < WORDS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_SWEEP);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    assign rd_data   = bank_q[rd_addr];

    for (genvar g = 0; g < WORDS; g++) begin : g_flat
        assign cfg_q[g*WIDTH +: WIDTH] = bank_q[g];
    end

endmodule

// File: tb/tb_cfg_bank_loader.sv
module tb_cfg_bank_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [63:0] cfg_q;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    cfg_bank_loader #(.WORDS(8), .WIDTH(8), .AW(3), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .R         (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cfg_q     (cfg_q)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [2:0]  len;
        logic [63:0] data;   // LOAD word k at [k*8 +: 8]
        logic        gaps;   // insert a wr_valid-low cycle before each word
        logic [63:0] exp;    // expected cfg_q after completion
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command from IDLE and follow it to the cycle after done.
    task automatic run_vec(input vec_t v);
        int cyc;
        int exp_cyc;
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(posedge clk); #1;
        // Keep offering a full-bank SET while busy; it must never be taken.
        cmd_op   = 2'b10;
        cmd_addr = 3'd0;
        cmd_len  = 3'd7;
        if (v.op == 2'b00) begin
            for (int k = 0; k <= int'(v.len); k++) begin
                if (v.gaps) begin
                    wr_valid = 1'b0;
                    chk("load_gap_wr_ready", {63'd0, wr_ready}, 64'd1);
                    chk("load_gap_no_done", {63'd0, done}, 64'd0);
                    @(posedge clk); #1;
                end
                wr_valid = 1'b1;
                wr_data  = v.data[k*8 +: 8];
                chk("load_wr_ready", {63'd0, wr_ready}, 64'd1);
                chk("load_cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
                chk("load_busy", {63'd0, busy}, 64'd1);
                @(posedge clk); #1;
            end
            wr_valid  = 1'b0;
            cmd_valid = 1'b0;
        end else begin
            cyc      = 0;
            exp_cyc  = (v.op == 2'b11) ? 0 : int'(v.len) + 1;
            wr_valid = (v.op != 2'b11);
            wr_data  = 8'h77;
            while (!done && cyc < 20) begin
                chk("sweep_busy", {63'd0, busy}, 64'd1);
                chk("sweep_wr_ready", {63'd0, wr_ready}, 64'd0);
                chk("sweep_cmd_ready", {63'd0, cmd_ready}, 64'd0);
                @(posedge clk); #1;
                cyc++;
            end
            wr_valid  = 1'b0;
            cmd_valid = 1'b0;
            chk("sweep_latency", 64'(cyc), 64'(exp_cyc));
        end
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_not_aborted", {63'd0, aborted}, 64'd0);
        chk("done_not_busy", {63'd0, busy}, 64'd0);
        chk("done_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("bank", cfg_q, v.exp);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk("rd_data", {56'd0, rd_data}, {56'd0, v.exp[i*8 +: 8]});
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        vec_t v;
        logic seen_done;

        vt[0] = '{2'b00, 3'd2, 3'd2, 64'h0000_0000_00FF_3CA5, 1'b1, 64'h0000_00FF_3CA5_0000};
        vt[1] = '{2'b10, 3'd6, 3'd3, 64'h0, 1'b0, 64'hFFFF_00FF_3CA5_FFFF};
        vt[2] = '{2'b01, 3'd0, 3'd7, 64'h0, 1'b0, 64'h0000_0000_0000_0000};
        vt[3] = '{2'b10, 3'd0, 3'd7, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[4] = '{2'b00, 3'd7, 3'd1, 64'h0000_0000_0000_3412, 1'b0, 64'h12FF_FFFF_FFFF_FF34};
        vt[5] = '{2'b11, 3'd4, 3'd5, 64'h0, 1'b0, 64'h12FF_FFFF_FFFF_FF34};
        vt[6] = '{2'b01, 3'd3, 3'd0, 64'h0, 1'b0, 64'h12FF_FFFF_00FF_FF34};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; abort = 1'b0; rd_addr = '0;
        #3;
        chk("rst_bank", cfg_q, 64'h0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("rst_status", {61'd0, busy, done, aborted}, 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            run_vec(vt[t]);
        end

        // Abort coincident with the 2nd data handshake of a 4-word LOAD.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'd0; cmd_len = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 8'h5A;
        @(posedge clk); #1;
        wr_data = 8'hC3; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; wr_valid = 1'b0;
        chk("abort_done", {63'd0, done}, 64'd1);
        chk("abort_aborted", {63'd0, aborted}, 64'd1);
        chk("abort_bank", cfg_q, 64'h12FF_FFFF_00FF_FF5A);
        @(posedge clk); #1;
        chk("abort_pulse_end", {62'd0, done, aborted}, 64'd0);
        v = '{2'b01, 3'd1, 3'd0, 64'h0, 1'b0, 64'h12FF_FFFF_00FF_005A};
        run_vec(v);

        // abort in IDLE has no effect.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_ignored", {61'd0, busy, done, aborted}, 64'd0);
        chk("idle_abort_bank", cfg_q, 64'h12FF_FFFF_00FF_005A);

        // Reset in the middle of a full-bank SET.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 3'd0; cmd_len = 3'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_sweep_partial", cfg_q, 64'h12FF_FFFF_00FF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bank", cfg_q, 64'h0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        #3 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("no_done_after_reset", {63'd0, seen_done}, 64'd0);
        chk("post_reset_bank", cfg_q, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
